// File: rtl/midi_msg_decoder.sv
// midi_msg_decoder: MIDI channel-voice message decoder with running status, SysEx skip and real-time pass-through
//   i_clk, i_rst (async, active-high), i_valid/i_data: byte stream from midi_rx
//   o_msg_valid/o_msg_type/o_channel/o_data1/o_data2: one-cycle complete-message record
//   o_rt_valid/o_rt_byte: one-cycle real-time byte pass-through
//   o_error: one-cycle pulse for a data byte with no running status
module midi_msg_decoder #(
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
    parameter bit          VEL0_IS_OFF  = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_msg_valid,
    output logic [2:0] o_msg_type,
    output logic [3:0] o_channel,
    output logic [6:0] o_data1,
    output logic [6:0] o_data2,
    output logic       o_rt_valid,
    output logic [7:0] o_rt_byte,
    output logic       o_error
);
    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;
    state_t     state_q, state_d;
    logic [2:0] rs_type_q, rs_type_d, msg_type_q, msg_type_d, type_v;
    logic [3:0] rs_chan_q, rs_chan_d, channel_q, channel_d;
    logic [6:0] d1_q, d1_d, data1_q, data1_d, data2_q, data2_d, d1_v, d2_v;
    logic [7:0] rt_byte_q, rt_byte_d;
    logic       msg_valid_q, msg_valid_d, rt_valid_q, rt_valid_d, error_q, error_d;
    logic       is_data, is_rt, is_chan, is_sys, one_byte, done, emit;
    always_comb begin
        is_data  = i_valid && !i_data[7];
        is_rt    = i_valid && i_data >= 8'hF8;
        is_chan  = i_valid && i_data[7] && i_data < 8'hF0;
        is_sys   = i_valid && i_data >= 8'hF0 && i_data < 8'hF8;
        one_byte = rs_type_q == 3'd4 || rs_type_q == 3'd5;
        done     = is_data && (state_q == WAIT_D2 || (state_q == WAIT_D1 && one_byte));
        emit     = done && CHANNEL_MASK[rs_chan_q];
        d1_v     = state_q == WAIT_D2 ? d1_q : i_data[6:0];
        d2_v     = state_q == WAIT_D2 ? i_data[6:0] : 7'd0;
        // NOTE_ON with zero velocity is folded into NOTE_OFF when enabled
        type_v   = (VEL0_IS_OFF && rs_type_q == 3'd1 && d2_v == 7'd0) ? 3'd0 : rs_type_q;
        // any system-common byte other than F0 (including F7 ending SysEx) clears running status
        state_d  = is_chan ? WAIT_D1 :
                   (is_sys && i_data == 8'hF0) ? SYSEX :
                   is_sys ? IDLE :
                   (is_data && state_q == WAIT_D1 && !one_byte) ? WAIT_D2 :
                   done ? WAIT_D1 : state_q;
        rs_type_d   = is_chan ? i_data[6:4] : rs_type_q;
        rs_chan_d   = is_chan ? i_data[3:0] : rs_chan_q;
        d1_d        = (is_data && state_q == WAIT_D1) ? i_data[6:0] : d1_q;
        msg_valid_d = emit;
        msg_type_d  = emit ? type_v : msg_type_q;
        channel_d   = emit ? rs_chan_q : channel_q;
        data1_d     = emit ? d1_v : data1_q;
        data2_d     = emit ? d2_v : data2_q;
        rt_valid_d  = is_rt;
        rt_byte_d   = is_rt ? i_data : rt_byte_q;
        error_d     = is_data && state_q == IDLE;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            rs_type_q   <= '0;
            rs_chan_q   <= '0;
            d1_q        <= '0;
            msg_valid_q <= 1'b0;
            msg_type_q  <= '0;
            channel_q   <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            rt_valid_q  <= 1'b0;
            rt_byte_q   <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_type_q   <= rs_type_d;
            rs_chan_q   <= rs_chan_d;
            d1_q        <= d1_d;
            msg_valid_q <= msg_valid_d;
            msg_type_q  <= msg_type_d;
            channel_q   <= channel_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            rt_valid_q  <= rt_valid_d;
            rt_byte_q   <= rt_byte_d;
            error_q     <= error_d;
        end
    end
    assign o_msg_valid = msg_valid_q;
    assign o_msg_type  = msg_type_q;
    assign o_channel   = channel_q;
    assign o_data1     = data1_q;
    assign o_data2     = data2_q;
    assign o_rt_valid  = rt_valid_q;
    assign o_rt_byte   = rt_byte_q;
    assign o_error     = error_q;
endmodule

// File: tb/tb_midi_msg_decoder.sv
// tb_midi_msg_decoder: directed self-checking bench for midi_msg_decoder (default and channel-0-only/no-fold instances)
module tb_midi_msg_decoder;
    logic       clk = 1'b0, rst = 1'b1, i_valid = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       mv, rv, er, mv_m, rv_m, er_m;
    logic [2:0] ty, ty_m;
    logic [3:0] ch, ch_m;
    logic [6:0] d1, d2, d1_m, d2_m;
    logic [7:0] rb, rb_m;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    midi_msg_decoder dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_data(i_data),
        .o_msg_valid(mv), .o_msg_type(ty), .o_channel(ch), .o_data1(d1), .o_data2(d2),
        .o_rt_valid(rv), .o_rt_byte(rb), .o_error(er)
    );
    midi_msg_decoder #(.CHANNEL_MASK(16'h0001), .VEL0_IS_OFF(1'b0)) dut_m (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_data(i_data),
        .o_msg_valid(mv_m), .o_msg_type(ty_m), .o_channel(ch_m), .o_data1(d1_m), .o_data2(d2_m),
        .o_rt_valid(rv_m), .o_rt_byte(rb_m), .o_error(er_m)
    );

    // one strobe cycle; returns at the following negedge where that byte's outputs are visible
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = b;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({mv, ty, ch, d1, d2, rv, rb, er} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_dut: got %h required 0", {mv, ty, ch, d1, d2, rv, rb, er});
        end
        n_checks++;
        if ({mv_m, ty_m, ch_m, d1_m, d2_m, rv_m, rb_m, er_m} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_dut_m: got %h required 0", {mv_m, ty_m, ch_m, d1_m, d2_m, rv_m, rb_m, er_m});
        end
        rst = 1'b0;
    endtask

    task automatic test_note_on();
        send(8'h90);
        send(8'h3C);
        n_checks++;
        if (mv !== 1'b0) begin n_fail++; $display("FAIL note_on_early: got %b required 0", mv); end
        send(8'h64);
        n_checks++;
        if ({mv, ty, ch, d1, d2} !== {1'b1, 3'd1, 4'd0, 7'd60, 7'd100}) begin
            n_fail++;
            $display("FAIL note_on: got v%b t%0d c%0d %0d/%0d required v1 t1 c0 60/100", mv, ty, ch, d1, d2);
        end
        @(negedge clk);
        n_checks++;
        if ({mv, ty, ch, d1, d2} !== {1'b0, 3'd1, 4'd0, 7'd60, 7'd100}) begin
            n_fail++;
            $display("FAIL note_on_hold: got v%b t%0d c%0d %0d/%0d required v0 t1 c0 60/100", mv, ty, ch, d1, d2);
        end
    endtask

    task automatic test_vel0();
        send(8'h3E);
        send(8'h00);
        n_checks++;
        if ({mv, ty, ch, d1, d2} !== {1'b1, 3'd0, 4'd0, 7'd62, 7'd0}) begin
            n_fail++;
            $display("FAIL vel0_fold: got v%b t%0d c%0d %0d/%0d required v1 t0 c0 62/0", mv, ty, ch, d1, d2);
        end
        n_checks++;
        if ({mv_m, ty_m, d1_m, d2_m} !== {1'b1, 3'd1, 7'd62, 7'd0}) begin
            n_fail++;
            $display("FAIL vel0_nofold: got v%b t%0d %0d/%0d required v1 t1 62/0", mv_m, ty_m, d1_m, d2_m);
        end
    endtask

    task automatic test_realtime();
        send(8'h90);
        send(8'h3C);
        send(8'hF8);
        n_checks++;
        if ({rv, rb, mv} !== {1'b1, 8'hF8, 1'b0}) begin
            n_fail++;
            $display("FAIL rt_pulse: got rv%b rb%h mv%b required rv1 rbf8 mv0", rv, rb, mv);
        end
        send(8'h64);
        n_checks++;
        if ({mv, ty, ch, d1, d2, rv} !== {1'b1, 3'd1, 4'd0, 7'd60, 7'd100, 1'b0}) begin
            n_fail++;
            $display("FAIL rt_then_msg: got v%b t%0d c%0d %0d/%0d rv%b required v1 t1 c0 60/100 rv0", mv, ty, ch, d1, d2, rv);
        end
    endtask

    task automatic test_prog();
        send(8'hC5);
        send(8'h07);
        n_checks++;
        if ({mv, ty, ch, d1, d2} !== {1'b1, 3'd4, 4'd5, 7'd7, 7'd0}) begin
            n_fail++;
            $display("FAIL prog: got v%b t%0d c%0d %0d/%0d required v1 t4 c5 7/0", mv, ty, ch, d1, d2);
        end
        n_checks++;
        if (mv_m !== 1'b0) begin n_fail++; $display("FAIL prog_filtered: got %b required 0", mv_m); end
        send(8'h08);
        n_checks++;
        if ({mv, ty, ch, d1, d2} !== {1'b1, 3'd4, 4'd5, 7'd8, 7'd0}) begin
            n_fail++;
            $display("FAIL prog_running: got v%b t%0d c%0d %0d/%0d required v1 t4 c5 8/0", mv, ty, ch, d1, d2);
        end
    endtask

    task automatic test_filter();
        send(8'h91);
        send(8'h3C);
        send(8'h64);
        n_checks++;
        if (mv_m !== 1'b0) begin n_fail++; $display("FAIL filter_block: got %b required 0", mv_m); end
        n_checks++;
        if ({mv, ch} !== {1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL filter_pass_all: got v%b c%0d required v1 c1", mv, ch);
        end
        send(8'h90);
        send(8'h3C);
        send(8'h64);
        n_checks++;
        if ({mv_m, ty_m, ch_m, d1_m, d2_m} !== {1'b1, 3'd1, 4'd0, 7'd60, 7'd100}) begin
            n_fail++;
            $display("FAIL filter_ch0: got v%b t%0d c%0d %0d/%0d required v1 t1 c0 60/100", mv_m, ty_m, ch_m, d1_m, d2_m);
        end
    endtask

    task automatic test_other_types();
        send(8'hE3);
        send(8'h00);
        send(8'h40);
        n_checks++;
        if ({mv, ty, ch, d1, d2} !== {1'b1, 3'd6, 4'd3, 7'd0, 7'd64}) begin
            n_fail++;
            $display("FAIL pitch: got v%b t%0d c%0d %0d/%0d required v1 t6 c3 0/64", mv, ty, ch, d1, d2);
        end
        send(8'hDA);
        send(8'h55);
        n_checks++;
        if ({mv, ty, ch, d1, d2} !== {1'b1, 3'd5, 4'd10, 7'd85, 7'd0}) begin
            n_fail++;
            $display("FAIL chan_at: got v%b t%0d c%0d %0d/%0d required v1 t5 c10 85/0", mv, ty, ch, d1, d2);
        end
        // new status mid-message drops the partial note-on
        send(8'h90);
        send(8'h3C);
        send(8'h80);
        n_checks++;
        if (mv !== 1'b0) begin n_fail++; $display("FAIL drop_partial: got %b required 0", mv); end
        send(8'h3C);
        send(8'h40);
        n_checks++;
        if ({mv, ty, ch, d1, d2} !== {1'b1, 3'd0, 4'd0, 7'd60, 7'd64}) begin
            n_fail++;
            $display("FAIL note_off: got v%b t%0d c%0d %0d/%0d required v1 t0 c0 60/64", mv, ty, ch, d1, d2);
        end
        send(8'hF1);
        send(8'h3C);
        n_checks++;
        if ({er, mv} !== 2'b10) begin
            n_fail++;
            $display("FAIL syscommon_clear: got er%b mv%b required er1 mv0", er, mv);
        end
    endtask

    task automatic test_error();
        do_reset();
        send(8'h40);
        n_checks++;
        if ({er, mv} !== 2'b10) begin n_fail++; $display("FAIL error_idle: got er%b mv%b required er1 mv0", er, mv); end
        @(negedge clk);
        n_checks++;
        if (er !== 1'b0) begin n_fail++; $display("FAIL error_width: got %b required 0", er); end
        send(8'hF0);
        send(8'h7E);
        n_checks++;
        if ({er, mv} !== 2'b00) begin n_fail++; $display("FAIL sysex_data: got er%b mv%b required 00", er, mv); end
        send(8'h01);
        send(8'hF7);
        send(8'h40);
        n_checks++;
        if ({er, mv} !== 2'b10) begin n_fail++; $display("FAIL sysex_end_err: got er%b mv%b required er1 mv0", er, mv); end
    endtask

    task automatic test_reset_mid();
        send(8'h90);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({mv, ty, ch, d1, d2, rv, rb, er} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h required 0", {mv, ty, ch, d1, d2, rv, rb, er});
        end
        @(negedge clk);
        rst = 1'b0;
        send(8'h3C);
        n_checks++;
        if ({er, mv} !== 2'b10) begin n_fail++; $display("FAIL reset_mid_d1: got er%b mv%b required er1 mv0", er, mv); end
        send(8'h64);
        n_checks++;
        if ({er, mv} !== 2'b10) begin n_fail++; $display("FAIL reset_mid_d2: got er%b mv%b required er1 mv0", er, mv); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 8'h90;
        @(negedge clk);
        i_data = 8'h3C;
        @(negedge clk);
        i_data = 8'h64;
        @(negedge clk);
        i_data = 8'h3D;
        n_checks++;
        if ({mv, d1, d2} !== {1'b1, 7'd60, 7'd100}) begin
            n_fail++;
            $display("FAIL b2b_first: got v%b %0d/%0d required v1 60/100", mv, d1, d2);
        end
        @(negedge clk);
        i_data = 8'h65;
        n_checks++;
        if (mv !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b required 0", mv); end
        @(negedge clk);
        i_valid = 1'b0;
        n_checks++;
        if ({mv, ty, d1, d2} !== {1'b1, 3'd1, 7'd61, 7'd101}) begin
            n_fail++;
            $display("FAIL b2b_second: got v%b t%0d %0d/%0d required v1 t1 61/101", mv, ty, d1, d2);
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_vel0();
        test_realtime();
        test_prog();
        test_filter();
        test_other_types();
        test_error();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
